signed_arith_sequencer: RTL
===========================

SIGNED_ARITH_SEQUENCER -- requirements
Module: signed_arith_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width; result width is 2*WIDTH and the multiply iteration count is WIDTH.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a request is presented on op/a/b.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port op, input, 2 bits: 00 ADD, 01 SUB (a-b), 10 MUL, 11 MAC/illegal (see Configuration).
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: two's-complement signed operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result and ovf are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port result, output, 2*WIDTH bits: signed result.
REQ-011 The block SHALL have port ovf, output, 1 bit: overflow flag qualified by out_valid.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL implement states IDLE, CALC and DONE.
REQ-014 in_ready SHALL equal (state==IDLE); a request is accepted on a rising edge where in_valid && in_ready, and op/a/b are registered on that edge.
REQ-015 For ADD and SUB, the accept edge SHALL move IDLE to DONE with result = sign-extended a+b or a-b; out_valid is high in the very next cycle.
REQ-016 For MUL, the accept edge SHALL move IDLE to CALC; there are exactly WIDTH CALC cycles of radix-2 Booth shift-add; the WIDTH-th CALC edge moves to DONE; out_valid rises WIDTH+1 cycles after the accept cycle.
REQ-017 The MUL result SHALL be the exact signed product; -128*-128 = 16384 (0x4000) for WIDTH=8.
REQ-018 ovf SHALL be 1 when result lies outside the signed WIDTH-bit range [-2^(WIDTH-1), 2^(WIDTH-1)-1]; MAC is the exception, see REQ-026.
REQ-019 In DONE, result, ovf and out_valid SHALL hold stable until out_valid && out_ready; that edge returns the block to IDLE.
REQ-020 A new request SHALL NOT be accepted on the same edge a result is consumed; back-to-back ADD throughput is one result per 2 cycles.
REQ-021 in_valid during CALC or DONE SHALL be ignored, with no effect on the state or the operands being processed.
REQ-022 out_ready SHALL be ignored while out_valid is low.

Reset
REQ-023 rst high at a rising edge SHALL force state IDLE, out_valid=0, result=0, ovf=0, busy=0, iteration counter=0 and accumulator=0; in_ready is 1 in the following cycle.
REQ-024 A reset during CALC or DONE SHALL abort the operation; no out_valid is produced for the aborted request.
REQ-025 rst SHALL take priority over a simultaneous in_valid or out_ready.

Configuration
REQ-026 With macro SIGNED_ARITH_MAC_EN defined, op=11 SHALL be MAC: a 2*WIDTH accumulator is updated to acc + a*b (wrapping) on entry to DONE; result = new acc; ovf = 2*WIDTH-bit signed overflow of that addition; latency is as MUL.
REQ-027 Without SIGNED_ARITH_MAC_EN, op=11 SHALL be illegal: IDLE moves to DONE with result=0 and ovf=1, latency as ADD, and no accumulator is synthesized.

Verification
REQ-028 Reset then ADD a=100, b=27 -> out_valid one cycle after accept, result=0x007F, ovf=0.
REQ-029 SUB a=-128 (0x80), b=1 -> result=0xFF7F (-129), ovf=1.
REQ-030 MUL a=0x80, b=0x80 with out_ready held 0 for 5 cycles -> out_valid exactly 9 cycles after accept, result=0x4000, ovf=1 and held stable; in_ready=0 throughout; return to IDLE on the out_ready edge.
REQ-031 MUL a=-3, b=7 with rst pulsed in the 4th CALC cycle -> no out_valid, busy=0, in_ready=1 after reset; a following MUL 5*6 gives result=0x001E.
REQ-032 With SIGNED_ARITH_MAC_EN: MAC 0x7F*0x7F issued four times -> results 0x3F01, 0x7E02, 0xBD03 with ovf=1 on the third, then 0xFC04 with ovf=0. Without the macro: op=11 -> result=0, ovf=1.

Source files
------------

// File: rtl/signed_arith_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : signed_arith_sequencer
// Description : Signed ADD / SUB / multi-cycle Booth MUL sequencer with a
//               valid/ready request side and a valid/ready result side.
//               Optional feature macro: SIGNED_ARITH_MAC_EN (op=11 becomes
//               multiply-accumulate into a 2*WIDTH accumulator; otherwise
//               op=11 is reported as illegal with result=0, ovf=1).
// Revision    : 1.0 - initial release
// ============================================================================
module signed_arith_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ovf,
  output logic                 busy
);

  localparam int RW = 2 * WIDTH;          // result width
  localparam int PW = 2 * WIDTH + 2;      // Booth register: {A(W+1), Q(W), q-1}
  localparam int CW = $clog2(WIDTH + 1);  // iteration counter width

  localparam logic [1:0]    OP_ADD   = 2'b00;
  localparam logic [1:0]    OP_SUB   = 2'b01;
  localparam logic [1:0]    OP_MUL   = 2'b10;
  localparam logic [1:0]    OP_MAC   = 2'b11;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_prod;
  logic [WIDTH-1:0]  r_mcand;
  logic              r_out_valid;
  logic [RW-1:0]     r_result;
  logic              r_ovf;

  logic [RW-1:0]     w_a_ext;
  logic [RW-1:0]     w_b_ext;
  logic [RW-1:0]     w_add;
  logic [RW-1:0]     w_sub;
  logic [WIDTH:0]    w_mcand_ext;
  logic [WIDTH:0]    w_upper;
  logic [WIDTH:0]    w_upper_sum;
  logic [PW-1:0]     w_prod_next;
  logic [RW-1:0]     w_product;

  // True when a 2*WIDTH-bit value does not fit in the signed WIDTH-bit range,
  // i.e. the bits from WIDTH-1 upward are not all copies of the sign.
  function automatic logic f_narrow_ovf(input logic [RW-1:0] v);
    return !((&v[RW-1:WIDTH-1]) || (~|v[RW-1:WIDTH-1]));
  endfunction

  assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_b_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign w_add   = w_a_ext + w_b_ext;
  assign w_sub   = w_a_ext - w_b_ext;

  // The partial-product half carries one guard bit so that subtracting the
  // most negative multiplicand cannot overflow before the arithmetic shift.
  assign w_mcand_ext = {r_mcand[WIDTH-1], r_mcand};
  assign w_upper     = r_prod[PW-1:WIDTH+1];

  // Booth recoding of the current multiplier bit pair {Q0, q-1}.
  always_comb begin
    w_upper_sum = w_upper;
    case (r_prod[1:0])
      2'b01:   w_upper_sum = w_upper + w_mcand_ext;
      2'b10:   w_upper_sum = w_upper - w_mcand_ext;
      default: w_upper_sum = w_upper;
    endcase
  end

  // Arithmetic shift right of the whole Booth register after the add step.
  assign w_prod_next = {w_upper_sum[WIDTH], w_upper_sum, r_prod[WIDTH:1]};
  // Exact signed product always fits in 2*WIDTH bits: drop guard bit and q-1.
  assign w_product   = w_prod_next[RW:1];

`ifdef SIGNED_ARITH_MAC_EN
  logic [RW-1:0] r_acc;
  logic          r_is_mac;
  logic [RW-1:0] w_acc_sum;
  logic          w_acc_ovf;

  assign w_acc_sum = r_acc + w_product;
  // Two's-complement overflow: same-sign operands producing a different sign.
  assign w_acc_ovf = (r_acc[RW-1] == w_product[RW-1]) &&
                     (w_acc_sum[RW-1] != r_acc[RW-1]);
`endif

  // Main sequencer: accept in IDLE, iterate in CALC, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_mcand     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
`ifdef SIGNED_ARITH_MAC_EN
      r_acc       <= '0;
      r_is_mac    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            case (op)
              OP_ADD: begin
                r_result    <= w_add;
                r_ovf       <= f_narrow_ovf(w_add);
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
              end
              OP_SUB: begin
                r_result    <= w_sub;
                r_ovf       <= f_narrow_ovf(w_sub);
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
              end
              OP_MUL: begin
                r_prod   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
                r_mcand  <= a;
                r_cnt    <= '0;
                r_state  <= S_CALC;
`ifdef SIGNED_ARITH_MAC_EN
                r_is_mac <= 1'b0;
`endif
              end
              OP_MAC: begin
`ifdef SIGNED_ARITH_MAC_EN
                r_prod   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
                r_mcand  <= a;
                r_cnt    <= '0;
                r_state  <= S_CALC;
                r_is_mac <= 1'b1;
`else
                // Illegal opcode: flag it immediately with a zero result.
                r_result    <= '0;
                r_ovf       <= 1'b1;
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
`endif
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end

        S_CALC: begin
          r_prod <= w_prod_next;
          if (r_cnt == CNT_LAST) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef SIGNED_ARITH_MAC_EN
            if (r_is_mac) begin
              r_acc    <= w_acc_sum;
              r_result <= w_acc_sum;
              r_ovf    <= w_acc_ovf;
            end else begin
              r_result <= w_product;
              r_ovf    <= f_narrow_ovf(w_product);
            end
`else
            r_result <= w_product;
            r_ovf    <= f_narrow_ovf(w_product);
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // Consuming edge only returns to IDLE; a new request waits a cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire
